// File: rtl/mul_pipe_tree.sv
// Pipelined WIDTH x WIDTH multiplier: registered operand stage, binary adder tree of
// partial products (one register level per stage), output register; valid/ready stall.
// Optional signed mode behind `define MUL_PIPE_TREE_SIGNED_EN (adds mul_signed input).
module mul_pipe_tree #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     mul_a,
    input  logic [WIDTH-1:0]     mul_b,
`ifdef MUL_PIPE_TREE_SIGNED_EN
    input  logic                 mul_signed,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   mul_out,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int LVL = $clog2(WIDTH);
    localparam int PW  = 2 * WIDTH;

    logic             advance;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             v0;
    logic             sgn_r;
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    pp [WIDTH];

    // A held output stalls the whole pipe, so nothing moves and nothing is accepted.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            v0  <= 1'b0;
        end else if (advance) begin
            v0  <= in_valid;
            a_r <= in_valid ? mul_a : '0;
            b_r <= in_valid ? mul_b : '0;
        end
    end

`ifdef MUL_PIPE_TREE_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_r <= 1'b0;
        end else if (advance) begin
            sgn_r <= in_valid && mul_signed;
        end
    end
`else
    assign sgn_r = 1'b0;
`endif

    // Two's complement: sign-extend a, and the MSB row of b carries negative weight.
    always_comb begin
        // NOTE: every output gets a default before any condition, so no latch is inferred.
        a_ext = {{WIDTH{sgn_r & a_r[WIDTH-1]}}, a_r};
        for (int i = 0; i < WIDTH; i++) begin
            pp[i] = '0;
            if (b_r[i]) pp[i] = a_ext << i;
        end
        if (sgn_r && b_r[WIDTH-1]) pp[WIDTH-1] = -(a_ext << (WIDTH - 1));
    end

    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
        localparam int N = WIDTH >> k;
        logic [PW-1:0] sum [N];
        logic [PW-1:0] src [2*N];
        logic          src_vld;
        logic          vld;

        if (k == 1) begin : g_src
            assign src     = pp;
            assign src_vld = v0;
        end else begin : g_src
            assign src     = g_lvl[k-1].sum;
            assign src_vld = g_lvl[k-1].vld;
        end

        // NOTE: tree data registers are reset too, so no stale sum can reach mul_out.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= 1'b0;
                for (int j = 0; j < N; j++) sum[j] <= '0;
            end else if (advance) begin
                vld <= src_vld;
                for (int j = 0; j < N; j++) sum[j] <= src[2*j] + src[2*j+1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            mul_out   <= '0;
        end else if (advance) begin
            out_valid <= g_lvl[LVL].vld;
            mul_out   <= g_lvl[LVL].vld ? g_lvl[LVL].sum[0] : '0;
        end
    end

endmodule

// File: tb/tb_mul_pipe_tree.sv
// Scoreboard bench for mul_pipe_tree: driver pushes hand-computed products, a monitor
// pops them as the DUT presents results; extra instances cover WIDTH=16 and WIDTH=2.
module tb_mul_pipe_tree;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mul_a = '0, mul_b = '0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [15:0] mul_out;
`ifdef MUL_PIPE_TREE_SIGNED_EN
    logic        mul_signed = 1'b0;
`endif

    logic [15:0] a16 = '0, b16 = '0;
    logic        v16 = 1'b0, rdy16, ov16;
    logic [31:0] p16;
    logic [1:0]  a2 = '0, b2 = '0;
    logic        v2 = 1'b0, rdy2, ov2;
    logic [3:0]  p2;

    mul_pipe_tree #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .mul_a(mul_a), .mul_b(mul_b),
`ifdef MUL_PIPE_TREE_SIGNED_EN
        .mul_signed(mul_signed),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .mul_out(mul_out),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mul_pipe_tree #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .mul_a(a16), .mul_b(b16),
`ifdef MUL_PIPE_TREE_SIGNED_EN
        .mul_signed(1'b0),
`endif
        .in_valid(v16), .in_ready(rdy16), .mul_out(p16),
        .out_valid(ov16), .out_ready(1'b1)
    );

    mul_pipe_tree #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mul_a(a2), .mul_b(b2),
`ifdef MUL_PIPE_TREE_SIGNED_EN
        .mul_signed(1'b0),
`endif
        .in_valid(v2), .in_ready(rdy2), .mul_out(p2),
        .out_valid(ov2), .out_ready(1'b1)
    );

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 2 time units after the falling edge, clear of driver updates.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", out_valid, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("product", mul_out, mon_e.val);
                if (mon_e.due >= 0) check("latency", cyc, mon_e.due);
            end
        end else if (rst_n && !out_valid) begin
            check("idle_zero", mul_out, 16'h0);
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input bit lat);
        int guard;
        mul_a    = a;
        mul_b    = b;
        in_valid = 1'b1;
`ifdef MUL_PIPE_TREE_SIGNED_EN
        mul_signed = s;
`endif
        #1;
        if (lat) check("in_ready_hi", in_ready, 1'b1);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1'b1);
        sb.push_back('{exp, lat ? cyc + 5 : -1});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        mul_a    = '0;
        mul_b    = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_mul_out", mul_out, 16'h0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single op, full latency and single-cycle valid.
        send(8'd255, 8'd255, 1'b0, 16'hFE01, 1'b1);
        idle(8);

        // Back-to-back ops, in_ready stays high, results on consecutive cycles.
        send(8'd3, 8'd5, 1'b0, 16'd15, 1'b1);
        send(8'd0, 8'd200, 1'b0, 16'd0, 1'b1);
        send(8'd128, 8'd2, 1'b0, 16'd256, 1'b1);
        idle(8);

        // Stream 4 ops and stall 3 cycles on the first result.
        fork
            begin
                send(8'd10, 8'd10, 1'b0, 16'd100, 1'b0);
                send(8'd7, 8'd9, 1'b0, 16'd63, 1'b0);
                send(8'd255, 8'd1, 1'b0, 16'd255, 1'b0);
                send(8'd16, 8'd16, 1'b0, 16'd256, 1'b0);
                in_valid = 1'b0;
            end
            begin
                g = 0;
                @(negedge clk);
                while (!out_valid && g < 30) begin
                    @(negedge clk);
                    g++;
                end
                check("stall_seen", out_valid, 1'b1);
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    #1;
                    check("stall_in_ready", in_ready, 1'b0);
                    check("stall_hold", mul_out, 16'd100);
                    check("stall_valid", out_valid, 1'b1);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle(12);

        // Reset with ops in flight: outputs drop at once, nothing appears after release.
        send(8'd1, 8'd2, 1'b0, 16'd2, 1'b1);
        send(8'd3, 8'd4, 1'b0, 16'd12, 1'b1);
        send(8'd5, 8'd6, 1'b0, 16'd30, 1'b1);
        idle(1);
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #2;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_out", mul_out, 16'h0);
        check("async_rst_ready", in_ready, 1'b1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

`ifdef MUL_PIPE_TREE_SIGNED_EN
        send(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b1);
        send(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1);
        send(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        idle(8);
`endif

        // Other widths: 16-bit and 2-bit extremes.
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
        v16 = 1'b1;
        @(negedge clk);
        v16 = 1'b0;
        g = 0;
        while (!ov16 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("w16_valid", ov16, 1'b1);
        check("w16_product", p16, 32'hFFFE0001);

        a2 = 2'd3;
        b2 = 2'd3;
        v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        g = 0;
        while (!ov2 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("w2_valid", ov2, 1'b1);
        check("w2_product", p2, 4'h9);

        idle(4);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
